k5_color_search: RTL and testbench

Sequential candidate generator and result collector wrapped around the combinational K5 proper-colouring checker. On `start` it walks every colouring of the five vertices over the colours 0..`max_color` in odometer order. It presents one candidate per cycle on `cand` and samples the checker's `proper` verdict in the same cycle. It stops on the first proper colouring, or when the space is exhausted, and reports the colouring and the number of candidates tried.

---
 rtl/k5_color_search_pkg.sv | 16 +
 rtl/k5_color_search_odometer.sv | 34 +++
 rtl/k5_color_search.sv | 99 +++++++++
 tb/tb_k5_color_search.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/k5_color_search_pkg.sv
// Shared constants, FSM state type and digit helper for the K5 colouring search.
package k5_pkg;
  localparam int NV     = 5;
  localparam int CB     = 3;
  localparam int CAND_W = NV * CB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [CB-1:0] digit(input logic [CAND_W-1:0] c, input int i);
    return c[i*CB +: CB];
  endfunction
endpackage

// File: rtl/k5_color_search_odometer.sv
// Combinational odometer step over five base-(lim+1) digits, vertex 0 least significant.
module color_odometer
  import k5_pkg::*;
(
  input  logic [CAND_W-1:0] cand_i,
  input  logic [CB-1:0]     lim_i,
  output logic [CAND_W-1:0] cand_nxt_o,
  output logic              last_o
);

  logic [CB-1:0] d;
  logic          carry;

  always_comb begin
    cand_nxt_o = cand_i;
    last_o     = 1'b1;
    carry      = 1'b1;
    d          = '0;
    for (int i = 0; i < NV; i++) begin
      d = digit(cand_i, i);
      if (d != lim_i) last_o = 1'b0;
      // A digit at the limit wraps and keeps the carry rippling upward.
      if (carry) begin
        if (d == lim_i) begin
          cand_nxt_o[i*CB +: CB] = '0;
        end else begin
          cand_nxt_o[i*CB +: CB] = CB'(d + 1'b1);
          carry                  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/k5_color_search.sv
// Walks all K5 colourings in odometer order, one per clock, and stops on the first proper one.
module k5_color_search
  import k5_pkg::*;
#(
  parameter int NV = k5_pkg::NV,
  parameter int CB = k5_pkg::CB,
  parameter int TW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CB-1:0]    max_color,
  output logic [NV*CB-1:0] cand,
  input  logic             proper,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [NV*CB-1:0] coloring,
  output logic [TW-1:0]    tries
);

  state_t            state_q, state_d;
  logic [CB-1:0]     lim_q, lim_d;
  logic [NV*CB-1:0]  cand_q, cand_d;
  logic [NV*CB-1:0]  coloring_q, coloring_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic              found_q, found_d;
  logic [NV*CB-1:0]  cand_nxt;
  logic              last;

  color_odometer u_odo (
    .cand_i     (cand_q),
    .lim_i      (lim_q),
    .cand_nxt_o (cand_nxt),
    .last_o     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lim_q      <= '0;
      cand_q     <= '0;
      coloring_q <= '0;
      tries_q    <= '0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lim_q      <= lim_d;
      cand_q     <= cand_d;
      coloring_q <= coloring_d;
      tries_q    <= tries_d;
      found_q    <= found_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    cand_d     = cand_q;
    coloring_d = coloring_q;
    tries_d    = tries_q;
    found_d    = found_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lim_d      = max_color;
          cand_d     = '0;
          tries_d    = '0;
          found_d    = 1'b0;
          coloring_d = '0;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        // Every cycle in SEARCH evaluates exactly one candidate.
        tries_d = tries_q + TW'(1);
        if (proper) begin
          coloring_d = cand_q;
          found_d    = 1'b1;
          state_d    = DONE;
        end else if (last) begin
          found_d = 1'b0;
          state_d = DONE;
        end else begin
          cand_d = cand_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cand     = cand_q;
  assign coloring = coloring_q;
  assign tries    = tries_q;
  assign found    = found_q;
  assign busy     = (state_q == SEARCH);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_k5_color_search.sv
// Bench for k5_color_search: models the K5 checker and an enumerating reference search.
module tb_k5_color_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  max_color = '0;
  logic [14:0] cand;
  logic        proper;
  logic        busy, done, found;
  logic [14:0] coloring;
  logic [15:0] tries;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  k5_color_search #(.NV(5), .CB(3), .TW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .max_color (max_color),
    .cand      (cand),
    .proper    (proper),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .coloring  (coloring),
    .tries     (tries)
  );

  function automatic bit distinct5(input logic [14:0] c);
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (c[i*3 +: 3] == c[j*3 +: 3]) return 1'b0;
    return 1'b1;
  endfunction

  assign proper = distinct5(cand);

  // Candidate number k (from 0) written as base-(m+1) digits, vertex 0 lowest.
  function automatic logic [14:0] enc(input int k, input int base);
    logic [14:0] c;
    int r;
    c = '0;
    r = k;
    for (int i = 0; i < 5; i++) begin
      c[i*3 +: 3] = 3'(r % base);
      r = r / base;
    end
    return c;
  endfunction

  task automatic ref_search(input int m, output bit f, output logic [14:0] col, output int n);
    int base, total;
    base = m + 1;
    total = base ** 5;
    f = 1'b0;
    col = '0;
    n = total;
    for (int k = 0; k < total; k++) begin
      if (distinct5(enc(k, base))) begin
        f = 1'b1;
        col = enc(k, base);
        n = k + 1;
        return;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_coloring"}, 32'(coloring), 32'd0);
    chk({tag, "_tries"}, 32'(tries), 32'd0);
    chk({tag, "_cand"}, 32'(cand), 32'd0);
  endtask

  // pulse_at / chg_at / rst_at are cycle offsets after the accepted start; -1 disables.
  task automatic run_search(input int m, input int pulse_at, input int chg_at, input int rst_at);
    bit          ef;
    logic [14:0] ec;
    int          en, cnt, bad;
    bit          fin;
    ref_search(m, ef, ec, en);
    @(negedge clk);
    max_color = 3'(m);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    cnt = 0;
    bad = 0;
    fin = 1'b0;
    while (!fin && cnt < 5000) begin
      if (cand !== enc(cnt, m + 1)) bad++;
      if (cnt == rst_at) begin
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_outputs("after_abort");
        return;
      end
      if (cnt == pulse_at) start = 1'b1;
      if (cnt == chg_at) max_color = 3'd0;
      @(posedge clk);
      #1 start = 1'b0;
      cnt++;
      if (done) fin = 1'b1;
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    chk("cand_sequence_errors", 32'(bad), 32'd0);
    chk("done_latency", 32'(cnt), 32'(en));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("found", 32'(found), 32'(ef));
    chk("coloring", 32'(coloring), 32'(ec));
    chk("tries", 32'(tries), 32'(en));
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 32'd1);
    chk("tries_held", 32'(tries), 32'(en));
    chk("cand_retained", 32'(cand), 32'(enc(en - 1, m + 1)));
  endtask

  initial begin
    #2 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk_reset_outputs("idle");

    chk("ref_m4_tries", 32'(195), 32'd195);
    run_search(4, -1, -1, -1);
    chk("m4_coloring_const", 32'(coloring), 32'h29C);
    chk("m4_tries_const", 32'(tries), 32'd195);
    run_search(7, -1, -1, -1);
    chk("m7_tries_const", 32'(tries), 32'd669);
    run_search(3, -1, -1, -1);
    chk("m3_tries_const", 32'(tries), 32'd1024);
    run_search(0, -1, -1, -1);
    chk("m0_tries_const", 32'(tries), 32'd1);
    run_search(4, 50, 60, -1);
    chk("ignored_coloring_const", 32'(coloring), 32'h29C);
    run_search(4, -1, -1, 100);
    run_search(4, -1, -1, -1);
    chk("post_reset_tries_const", 32'(tries), 32'd195);
    for (int r = 0; r < 5; r++) run_search(int'($urandom_range(0, 7)), -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
